text_console_writer: RTL and testbench
======================================

// Module: text_console_writer
// PURPOSE
//  Write-side engine for the dual-port text RAM used by the VGA text display.
//  Accepts a byte stream (ASCII plus control codes) over a valid/ready handshake.
//  Maintains a cursor and a current attribute, and issues 16-bit {attr,char} writes on the RAM write port.
//  The VGA renderer reads the same RAM on the other port; this block never reads it.
// PARAMETERS
//  COLS          32     text columns per row; power of 2, 2..64
//  ROWS          32     text rows; COLS*ROWS <= 1024
//  DEFAULT_ATTR  8'h07  attribute loaded at reset
//  FILL_CHAR     8'h20  character written by row/screen clear
// PORTS
//  clk        in   1   system clock; also drives RAM port A
//  rst_n      in   1   asynchronous active-low reset
//  in_data    in   8   input byte
//  in_valid   in   1   in_data valid
//  in_ready   out  1   byte accepted when in_valid & in_ready
//  clr        in   1   1-cycle clear-screen request
//  ram_ce     out  1   RAM write enable (cea)
//  ram_ad     out  10  RAM word address (ada)
//  ram_din    out  16  RAM write data {attr[7:0],char[7:0]}
//  cur_col    out  6   cursor column, 0..COLS-1
//  cur_row    out  6   cursor row, 0..ROWS-1
//  busy       out  1   clear sequence in progress
// BEHAVIOUR
//  Reset (async, rst_n=0)
//   - State IDLE; cursor (0,0); attr=DEFAULT_ATTR.
//   - ram_ce=0, ram_ad=0, ram_din=0, busy=0, in_ready=0.
//   - in_ready rises the first cycle after reset release.
//   - RAM contents are never touched by reset.
//   - Reset during a clear abandons it; rows already written stay written.
//  Outputs
//   - All outputs are registered.
//   - in_ready = state in {IDLE,ESC}.
//   - ram_ad = row*COLS + col.
//  Byte decoding (acceptance in cycle N)
//   - printable 0x20..0x7E: ram_ce=1 in N+1 at the current cursor with {attr,byte}; col+1.
//   - Column wrap: col==COLS-1 wraps to col 0 with a newline.
//   - 0x0D CR: col=0; no write.
//   - 0x08 BS: col-1 if col>0, else no change; no write.
//   - 0x0A LF: newline.
//   - 0x0C FF: same as clr.
//   - 0x1B: go to ESC; the next accepted byte becomes attr (no write); return to IDLE.
//   - Other codes: ignored; accepted, no write.
//  newline
//   - row = (row==ROWS-1) ? 0 : row+1. There is no scrolling; the display wraps to the top.
//   - Then CLR_ROW: COLS consecutive writes of {attr,FILL_CHAR} to the new row, col 0..COLS-1.
//   - in_ready=0 and busy=1 during CLR_ROW. Cursor col=0 when done.
//  clr / FF
//   - CLR_ALL: COLS*ROWS writes, address 0..COLS*ROWS-1, one per cycle.
//   - Cursor ends at (0,0); busy=1 throughout.
//  Priority and edge cases
//   - clr in the same cycle as an accepted byte: clr wins; the byte is not consumed.
//   - clr during CLR_ROW or ESC: CLR_ROW aborts (ESC is dropped) and CLR_ALL starts next cycle.
//   - clr during CLR_ALL: ignored.
//   - in_valid held high with in_ready=0: no byte lost; the source must hold data.
//  State machine
//   - IDLE -> ESC, CLR_ROW or CLR_ALL.
//   - ESC -> IDLE.
//   - CLR_ROW -> IDLE after COLS writes.
//   - CLR_ALL -> IDLE after COLS*ROWS writes.
// STRUCTURE
//  text_console_pkg
//   - Control-code constants: CC_BS, CC_LF, CC_FF, CC_CR, CC_ESC.
//   - State encoding: IDLE, ESC, CLR_ROW, CLR_ALL.
//   - Word-pack function {attr,char}.
//  text_fill_seq (sub-module)
//   - Start/base/length counter producing sequential addresses and a done pulse.
//   - Used by both CLR_ROW and CLR_ALL.
//  Top level: byte decoder, cursor/attr registers, FSM, output registers.
// TESTING
//  1. Reset, then 'A'(0x41): one write, ad=0, din=16'h0741, ram_ce for 1 cycle; cursor (1,0).
//  2. 0x1B,0x1E,'B': no write for ESC/attr; write din=16'h1E42 at ad=1.
//  3. 32 x 'x' from (0,0): writes at ad 0..31; then 32 fill writes 16'h0720 at ad 32..63; cursor (0,1).
//  4. Cursor row 31, LF: row wraps to 0; fill at ad 0..31; in_ready=0 for 32 cycles.
//  5. clr with in_valid=1 same cycle: 1024 fill writes at ad 0..1023; byte accepted after busy falls.
//  6. rst_n low mid CLR_ALL (ad=500): all outputs reset at once; next 'C' written at ad=0.
//  7. BS at col 0, then CR: no write, cursor unchanged (0,row).

Source files
------------

// File: rtl/text_console_pkg.sv
// text_console_pkg
//   Shared definitions for the text console write engine.
//   - Control-code constants understood by the byte decoder.
//   - State encoding of the writer FSM.
//   - pack_word: builds the 16-bit {attr,char} RAM word.
package text_console_pkg;

  localparam logic [7:0] CC_BS  = 8'h08;
  localparam logic [7:0] CC_LF  = 8'h0A;
  localparam logic [7:0] CC_FF  = 8'h0C;
  localparam logic [7:0] CC_CR  = 8'h0D;
  localparam logic [7:0] CC_ESC = 8'h1B;

  localparam logic [7:0] PRINT_LO = 8'h20;
  localparam logic [7:0] PRINT_HI = 8'h7E;

  typedef enum logic [1:0] {
    IDLE,
    ESC,
    CLR_ROW,
    CLR_ALL
  } state_t;

  function automatic logic [15:0] pack_word(input logic [7:0] attr, input logic [7:0] ch);
    return {attr, ch};
  endfunction

endpackage

// File: rtl/text_fill_seq.sv
// text_fill_seq
//   Sequential address generator for the clear operations. A start pulse
//   loads a base address and a length; the generator then presents one
//   address per cycle and raises done on the last one.
// Ports
//   clk    in   1   clock
//   rst_n  in   1   asynchronous active-low reset
//   start  in   1   load base/len (also restarts a run already in progress)
//   base   in   10  first address
//   len    in   11  number of addresses, 1..1024
//   addr   out  10  current address, valid while a run is active
//   done   out  1   high while addr is the last address of the run
module text_fill_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [9:0]  base,
  input  logic [10:0] len,
  output logic [9:0]  addr,
  output logic        done
);

  logic        active;
  logic [10:0] remaining;

  // remaining counts addresses still to come after the current one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active    <= 1'b0;
      addr      <= '0;
      remaining <= '0;
    end else if (start) begin
      active    <= 1'b1;
      addr      <= base;
      remaining <= len - 11'd1;
    end else if (active) begin
      addr <= addr + 10'd1;
      if (remaining == 11'd0) begin
        active <= 1'b0;
      end else begin
        remaining <= remaining - 11'd1;
      end
    end
  end

  assign done = active && (remaining == 11'd0);

endmodule

// File: rtl/text_console_writer.sv
// text_console_writer
//   Write-side engine for the dual-port VGA text RAM. Decodes a byte stream
//   (printable ASCII plus control codes), keeps the cursor and current
//   attribute, and issues {attr,char} writes on RAM port A. Newline clears
//   the new row; clr / FF clears the whole screen. Never reads the RAM.
// Ports
//   clk       in   1   system clock, also RAM port A clock
//   rst_n     in   1   asynchronous active-low reset
//   in_data   in   8   input byte
//   in_valid  in   1   in_data valid
//   in_ready  out  1   byte accepted when in_valid & in_ready
//   clr       in   1   one-cycle clear-screen request
//   ram_ce    out  1   RAM write enable
//   ram_ad    out  10  RAM word address (row*COLS + col)
//   ram_din   out  16  RAM write data {attr,char}
//   cur_col   out  6   cursor column
//   cur_row   out  6   cursor row
//   busy      out  1   row or screen clear in progress
module text_console_writer
  import text_console_pkg::*;
#(
  parameter int         COLS         = 32,
  parameter int         ROWS         = 32,
  parameter logic [7:0] DEFAULT_ATTR = 8'h07,
  parameter logic [7:0] FILL_CHAR    = 8'h20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        clr,
  output logic        ram_ce,
  output logic [9:0]  ram_ad,
  output logic [15:0] ram_din,
  output logic [5:0]  cur_col,
  output logic [5:0]  cur_row,
  output logic        busy
);

  localparam int          COL_BITS   = $clog2(COLS);
  localparam logic [5:0]  LAST_COL   = 6'(COLS - 1);
  localparam logic [5:0]  LAST_ROW   = 6'(ROWS - 1);
  localparam logic [10:0] SCREEN_LEN = 11'(COLS * ROWS);
  localparam logic [10:0] ROW_LEN    = 11'(COLS);

  state_t      state;
  logic [7:0]  attr;
  logic [5:0]  next_row;
  logic [9:0]  cursor_ad;
  logic [9:0]  next_row_ad;
  logic        is_print;
  logic        accept;
  logic        all_start;
  logic        row_start;
  logic        seq_start;
  logic [9:0]  seq_base;
  logic [10:0] seq_len;
  logic [9:0]  seq_ad;
  logic        seq_done;

  // Request decode. A clr pulse beats a byte offered in the same cycle, so
  // accept excludes clr and the byte stays pending at the source.
  always_comb begin
    next_row    = (cur_row == LAST_ROW) ? 6'd0 : cur_row + 6'd1;
    cursor_ad   = (10'(cur_row) << COL_BITS) | 10'(cur_col);
    next_row_ad = 10'(next_row) << COL_BITS;
    is_print    = (in_data >= PRINT_LO) && (in_data <= PRINT_HI);
    accept      = in_valid && in_ready && !clr;
    all_start   = (clr && (state != CLR_ALL)) ||
                  (accept && (state == IDLE) && (in_data == CC_FF));
    row_start   = accept && (state == IDLE) &&
                  ((is_print && (cur_col == LAST_COL)) || (in_data == CC_LF));
    seq_start   = all_start || row_start;
    seq_base    = all_start ? 10'd0 : next_row_ad;
    seq_len     = all_start ? SCREEN_LEN : ROW_LEN;
  end

  text_fill_seq u_fill (
    .clk   (clk),
    .rst_n (rst_n),
    .start (seq_start),
    .base  (seq_base),
    .len   (seq_len),
    .addr  (seq_ad),
    .done  (seq_done)
  );

  // Writer FSM with registered handshake, status and RAM port outputs.
  // A screen clear pre-empts everything except a clear already running;
  // the clr cycle itself issues no write, filling starts the next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      attr     <= DEFAULT_ATTR;
      cur_col  <= '0;
      cur_row  <= '0;
      ram_ce   <= 1'b0;
      ram_ad   <= '0;
      ram_din  <= '0;
      busy     <= 1'b0;
      in_ready <= 1'b0;
    end else begin
      ram_ce <= 1'b0;
      if (all_start) begin
        state    <= CLR_ALL;
        in_ready <= 1'b0;
        busy     <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            in_ready <= 1'b1;
            if (accept) begin
              if (is_print) begin
                ram_ce  <= 1'b1;
                ram_ad  <= cursor_ad;
                ram_din <= pack_word(attr, in_data);
                // At the last column the wrap is handled by row_start.
                if (cur_col != LAST_COL) begin
                  cur_col <= cur_col + 6'd1;
                end
              end else if (in_data == CC_CR) begin
                cur_col <= '0;
              end else if (in_data == CC_BS) begin
                if (cur_col != 6'd0) begin
                  cur_col <= cur_col - 6'd1;
                end
              end else if (in_data == CC_ESC) begin
                state <= ESC;
              end
              if (row_start) begin
                cur_row  <= next_row;
                state    <= CLR_ROW;
                in_ready <= 1'b0;
                busy     <= 1'b1;
              end
            end
          end
          ESC: begin
            if (accept) begin
              attr  <= in_data;
              state <= IDLE;
            end
          end
          CLR_ROW, CLR_ALL: begin
            ram_ce  <= 1'b1;
            ram_ad  <= seq_ad;
            ram_din <= pack_word(attr, FILL_CHAR);
            if (seq_done) begin
              state    <= IDLE;
              in_ready <= 1'b1;
              busy     <= 1'b0;
              cur_col  <= '0;
              if (state == CLR_ALL) begin
                cur_row <= '0;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_text_console_writer.sv
// tb_text_console_writer
//   Self-checking bench for text_console_writer. Directed scenarios plus a
//   random byte stream; every RAM write the DUT issues is compared, in order,
//   against a screen model built from the console rules (cursor arithmetic,
//   newline fills, screen clears).
module tb_text_console_writer;

  localparam int         COLS = 32;
  localparam int         ROWS = 32;
  localparam logic [7:0] FILL = 8'h20;

  logic        clk;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        clr;
  logic        ram_ce;
  logic [9:0]  ram_ad;
  logic [15:0] ram_din;
  logic [5:0]  cur_col;
  logic [5:0]  cur_row;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int         m_col;
  int         m_row;
  logic [7:0] m_attr;
  bit         m_esc;
  logic [25:0] exp_q[$];
  logic [25:0] dut_q[$];

  text_console_writer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .clr      (clr),
    .ram_ce   (ram_ce),
    .ram_ad   (ram_ad),
    .ram_din  (ram_din),
    .cur_col  (cur_col),
    .cur_row  (cur_row),
    .busy     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Record every write the DUT issues, just after the edge that produced it.
  always @(posedge clk) begin
    #1;
    if (rst_n && ram_ce) dut_q.push_back({ram_ad, ram_din});
  end

  function automatic void model_reset();
    m_col  = 0;
    m_row  = 0;
    m_attr = 8'h07;
    m_esc  = 1'b0;
  endfunction

  function automatic void model_fill(input int first, input int count);
    for (int k = 0; k < count; k++) exp_q.push_back({10'(first + k), m_attr, FILL});
  endfunction

  function automatic void model_newline();
    m_row = (m_row + 1) % ROWS;
    model_fill(m_row * COLS, COLS);
    m_col = 0;
  endfunction

  function automatic void model_clear();
    model_fill(0, COLS * ROWS);
    m_row = 0;
    m_col = 0;
    m_esc = 1'b0;
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    if (m_esc) begin
      m_attr = b;
      m_esc  = 1'b0;
    end else if (b >= 8'h20 && b <= 8'h7E) begin
      exp_q.push_back({10'(m_row * COLS + m_col), m_attr, b});
      m_col++;
      if (m_col == COLS) model_newline();
    end else begin
      case (b)
        8'h0D: m_col = 0;
        8'h08: if (m_col > 0) m_col--;
        8'h0A: model_newline();
        8'h0C: model_clear();
        8'h1B: m_esc = 1'b1;
        default: ;
      endcase
    end
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge right after acceptance.
  task automatic applyStimulus(input logic [7:0] b);
    int n = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("accept wait", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    model_byte(b);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(in_ready && !busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("idle wait", {30'd0, in_ready, busy}, 32'd2);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic compare_writes(input string tag);
    int n;
    int matched = 0;
    n = (dut_q.size() < exp_q.size()) ? dut_q.size() : exp_q.size();
    while (matched < n && dut_q[matched] === exp_q[matched]) matched++;
    checkOutput({tag, " write count"}, 32'(dut_q.size()), 32'(exp_q.size()));
    checkOutput({tag, " writes in order"}, 32'(matched), 32'(n));
    if (matched < n)
      $display("[TB] %s first differing write #%0d: dut=%h model=%h",
               tag, matched, dut_q[matched], exp_q[matched]);
    dut_q.delete();
    exp_q.delete();
  endtask

  task automatic check_cursor(input string tag);
    checkOutput({tag, " cursor col"}, 32'(cur_col), 32'(m_col));
    checkOutput({tag, " cursor row"}, 32'(cur_row), 32'(m_row));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    model_reset();
  endtask

  initial begin
    int n;
    logic [7:0] b;
    rst_n    = 1'b0;
    in_data  = 8'h00;
    in_valid = 1'b0;
    clr      = 1'b0;
    model_reset();

    // 1. Reset values, in_ready rising, single printable write
    repeat (3) @(negedge clk);
    checkOutput("reset ram_ce", 32'(ram_ce), 32'd0);
    checkOutput("reset ram_ad", 32'(ram_ad), 32'd0);
    checkOutput("reset ram_din", 32'(ram_din), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset in_ready", 32'(in_ready), 32'd0);
    checkOutput("reset cursor", {20'd0, cur_row, cur_col}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("in_ready after release", 32'(in_ready), 32'd1);
    applyStimulus(8'h41);
    checkOutput("A ram_ce", 32'(ram_ce), 32'd1);
    checkOutput("A ram_ad", 32'(ram_ad), 32'd0);
    checkOutput("A ram_din", 32'(ram_din), 32'h0741);
    @(negedge clk);
    checkOutput("A ram_ce one cycle", 32'(ram_ce), 32'd0);
    check_cursor("A");
    compare_writes("A");

    // 2. ESC sets the attribute without writing
    applyStimulus(8'h1B);
    applyStimulus(8'h1E);
    applyStimulus(8'h42);
    checkOutput("B ram_ad", 32'(ram_ad), 32'd1);
    checkOutput("B ram_din", 32'(ram_din), 32'h1E42);
    compare_writes("ESC attr");

    // 3. A full row of 'x' wraps and clears row 1
    do_reset();
    for (int i = 0; i < COLS; i++) applyStimulus(8'h78);
    wait_idle();
    compare_writes("row wrap");
    checkOutput("row wrap col", 32'(cur_col), 32'd0);
    checkOutput("row wrap row", 32'(cur_row), 32'd1);

    // 4. LF on the last row wraps to row 0; in_ready low for COLS cycles
    for (int i = 0; i < ROWS - 2; i++) applyStimulus(8'h0A);
    wait_idle();
    checkOutput("row before LF", 32'(cur_row), 32'(ROWS - 1));
    applyStimulus(8'h0A);
    n = 0;
    while (!in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    checkOutput("LF in_ready low cycles", 32'(n), 32'(COLS));
    checkOutput("LF wrapped row", 32'(cur_row), 32'd0);
    compare_writes("LF wrap");
    check_cursor("LF wrap");

    // 5. clr beats a byte offered in the same cycle
    in_data  = 8'h44;
    in_valid = 1'b1;
    pulse_clr();
    n = 0;
    while (busy && n < 2000) begin
      n++;
      @(negedge clk);
    end
    checkOutput("clr busy cycles", 32'(n), 32'(COLS * ROWS));
    checkOutput("in_ready after clr", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    model_clear();
    model_byte(8'h44);
    checkOutput("held byte ram_din", 32'(ram_din), 32'h0744);
    compare_writes("clr screen");
    check_cursor("clr screen");

    // 6. Reset in the middle of a screen clear
    pulse_clr();
    n = 0;
    while (!(ram_ce && ram_ad == 10'd500) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reached ad 500", 32'(ram_ad), 32'd500);
    rst_n = 1'b0;
    #1;
    checkOutput("midclr reset ram_ce", 32'(ram_ce), 32'd0);
    checkOutput("midclr reset ram_ad", 32'(ram_ad), 32'd0);
    checkOutput("midclr reset busy", 32'(busy), 32'd0);
    checkOutput("midclr reset in_ready", 32'(in_ready), 32'd0);
    model_fill(0, 501);
    compare_writes("partial clr");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    model_reset();
    applyStimulus(8'h43);
    checkOutput("C ram_ad", 32'(ram_ad), 32'd0);
    checkOutput("C ram_din", 32'(ram_din), 32'h0743);
    compare_writes("after reset");

    // 7. BS at column 0 and CR write nothing and leave the cursor alone
    applyStimulus(8'h0D);
    applyStimulus(8'h08);
    applyStimulus(8'h0D);
    @(negedge clk);
    checkOutput("BS/CR col", 32'(cur_col), 32'd0);
    check_cursor("BS/CR");
    compare_writes("BS/CR");
    applyStimulus(8'h45);
    applyStimulus(8'h46);
    applyStimulus(8'h08);
    check_cursor("BS mid row");

    // clr while waiting for an attribute byte drops the ESC
    applyStimulus(8'h1B);
    pulse_clr();
    model_clear();
    wait_idle();
    applyStimulus(8'h47);
    checkOutput("ESC dropped ram_din", 32'(ram_din), 32'h0747);
    compare_writes("ESC drop");

    // Random byte stream against the model
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        wait_idle();
        pulse_clr();
        model_clear();
      end
      n = $urandom_range(0, 99);
      if (n < 70)      b = 8'($urandom_range(32, 126));
      else if (n < 78) b = 8'h0A;
      else if (n < 84) b = 8'h0D;
      else if (n < 88) b = 8'h08;
      else if (n < 93) b = 8'h1B;
      else if (n < 96) b = 8'($urandom_range(0, 31));
      else             b = 8'($urandom_range(127, 255));
      applyStimulus(b);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    wait_idle();
    compare_writes("random");
    check_cursor("random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
